config_params_update_stage: RTL and testbench
=============================================

Name: config_params_update_stage

Overview:
- Downstream consumer of the per-response parameter-select stage.
- Takes its selected (param field, meta) stream, qualified by a pulse and a thermometer kernel-valid mask, and queues each capture in a small FIFO.
- Drains the FIFO through a valid/ready apply handshake into a per-slot shadow register bank.
- Runs a small epoch FSM that asserts config_ready_out once every slot in a latched expected mask has been applied.

Parameters:
- MASK_WIDTH, 8, number of parameter slots; equals the select stage's mask width.
- FIFO_DEPTH, 4, capture queue entries; power of two, >= 2.

Ports:
- ap_clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- pulse_in  in  1  select-stage pulse
- kernel_valid_in  in  MASK_WIDTH  thermometer slot select; lowest set bit = slot index
- config_params_in  in  ParallelReadWriteConfigurationParameterField  selected param field
- config_meta_in  in  ParallelReadWriteConfigurationMeta  selected meta
- start_in  in  1  begin new epoch
- expected_mask_in  in  MASK_WIDTH  slots required for ready; sampled on start_in
- apply_ready_in  in  1  consumer ready
- apply_valid_out  out  1  FIFO head valid
- apply_slot_out  out  $clog2(MASK_WIDTH)  head slot index
- apply_params_out  out  ParallelReadWriteConfigurationParameterField  head param
- params_bank_out  out  MASK_WIDTH x ParallelReadWriteConfigurationParameterField  applied params per slot
- meta_bank_out  out  MASK_WIDTH x ParallelReadWriteConfigurationMeta  applied meta per slot
- slot_updated_out  out  MASK_WIDTH  slots applied this epoch
- config_ready_out  out  1  expected slots all applied
- overflow_out  out  1  sticky: capture dropped because FIFO full
- drop_count_out  out  16  dropped-capture counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, banks 0, FIFO empty, FSM IDLE. All sequential state uses an async active-high reset on areset.
- Capture condition: capture = pulse_in & |kernel_valid_in. slot = index of the lowest set bit of kernel_valid_in, even when the mask is non-thermometer.
- FSM state IDLE: captures are discarded; overflow is not set. start_in -> ARMED.
- FSM state ARMED: captures are pushed. Transition to READY when FIFO empty, no push this cycle, and (slot_updated_out & expected_mask) == expected_mask. If expected_mask == 0, READY is reached on the next cycle.
- FSM state READY: config_ready_out = 1 (registered). Captures are still pushed and applied; the FSM stays in READY.
- start_in in any state:
  - flush FIFO; clear slot_updated_out and overflow_out;
  - latch expected_mask_in;
  - go to ARMED;
  - a capture in the same cycle is written after the flush (it belongs to the new epoch).
- Push: a capture at edge N is visible on apply_valid_out/apply_slot_out/apply_params_out from cycle N+1. The FIFO is show-ahead and outputs are registered.
- Full FIFO: a push is accepted only if a pop occurs in the same cycle. Otherwise the capture is dropped, overflow_out is set (sticky until start_in/reset), and the drop counter increments.
- Pop/apply: when apply_valid_out & apply_ready_in at an edge:
  - params_bank_out[slot] and meta_bank_out[slot] take the head entry;
  - slot_updated_out[slot] is set;
  - the head advances.
  - A repeated slot overwrites; last write wins.
- Simultaneous push and pop on an empty FIFO: the pop is invalid, so only the push takes effect.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer bit.
- Reset mid-epoch: everything returns to reset values immediately; in-flight entries are lost.

Optional Feature:
- Macro: CONFIG_PARAMS_UPDATE_DROP_COUNT_EN.
- Defined: drop_count_out is a 16-bit saturating counter (holds at 0xFFFF). It increments on every dropped capture in ARMED/READY, is cleared by start_in/reset, and counts discards in IDLE too.
- Undefined: drop_count_out is tied to 0 and no counter logic is generated; the port list is unchanged.

Decomposition:
- Shared package:
  - typedef ConfigParamsUpdateEntry {slot index, ParallelReadWriteConfigurationParameterField, ParallelReadWriteConfigurationMeta};
  - enum ConfigParamsUpdateState {IDLE, ARMED, READY};
  - constant CONFIG_PARAMS_UPDATE_DROP_COUNT_WIDTH = 16.
- Sub-module: config_params_update_fifo, a parameterised show-ahead FIFO of ConfigParamsUpdateEntry with push/pop/full/empty/flush.

Test Plan:
- Reset release, start_in with expected=8'b0000_0101; captures with kernel_valid=8'b1111_1111 (slot 0) then 8'b1111_1100 (slot 2), apply_ready=1 -> bank[0], bank[2] written; slot_updated=0x05; config_ready_out=1 two cycles after the last apply.
- ARMED, apply_ready=0, 5 captures into FIFO_DEPTH=4 -> first 4 queued, 5th dropped; overflow_out=1; drop_count_out=1 with macro, 0 without.
- Full FIFO, capture and apply handshake in the same cycle -> both occur; occupancy stays 4; no overflow.
- READY state, start_in concurrent with capture for slot 3 -> FIFO holds only the slot-3 entry; slot_updated=0; FSM ARMED; overflow cleared.
- Captures while IDLE and pulse_in=1 with kernel_valid=0 -> no push; apply_valid_out stays 0; banks unchanged.
- areset asserted asynchronously mid-drain with 3 entries queued -> all outputs 0 before the next clock edge; FIFO empty afterwards.

Source files
------------

// File: rtl/config_params_update_pkg.sv
// Shared types for the config parameter update stage: queued entry, epoch FSM states,
// and the drop counter width.
package config_params_update_pkg;

    typedef logic [31:0] ParallelReadWriteConfigurationParameterField;
    typedef logic [7:0]  ParallelReadWriteConfigurationMeta;

    localparam int CONFIG_PARAMS_UPDATE_DROP_COUNT_WIDTH = 16;
    localparam int CONFIG_PARAMS_UPDATE_MASK_WIDTH       = 8;
    // Entry slot field is sized for the default mask width of the select stage.
    localparam int CONFIG_PARAMS_UPDATE_SLOT_WIDTH       = $clog2(CONFIG_PARAMS_UPDATE_MASK_WIDTH);

    typedef struct packed {
        logic [CONFIG_PARAMS_UPDATE_SLOT_WIDTH-1:0]   slot;
        ParallelReadWriteConfigurationParameterField params;
        ParallelReadWriteConfigurationMeta           meta;
    } ConfigParamsUpdateEntry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        READY = 2'd2
    } ConfigParamsUpdateState;

endpackage

// File: rtl/config_params_update_fifo.sv
// Show-ahead FIFO of update entries with synchronous flush; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module config_params_update_fifo
    import config_params_update_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  ConfigParamsUpdateEntry entry,
    output ConfigParamsUpdateEntry head,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    ConfigParamsUpdateEntry mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_addr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & (flush | ~full | pop_ok);
    assign wr_addr = flush ? '0 : wr_ptr[AW-1:0];
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_addr] <= entry;
            end
            if (flush) begin
                // A capture coinciding with the flush becomes the first entry of the new epoch.
                rd_ptr <= '0;
                wr_ptr <= push_ok ? PTR_ONE : '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/config_params_update_stage.sv
// Captures selected parameter fields into a FIFO, applies them to per-slot shadow banks,
// and flags config ready per epoch. Optional macro: CONFIG_PARAMS_UPDATE_DROP_COUNT_EN.
//   state | meaning
//   IDLE  | no epoch open, captures discarded
//   ARMED | epoch open, waiting for all expected slots to be applied
//   READY | expected slots applied, config_ready_out high
module config_params_update_stage
    import config_params_update_pkg::*;
#(
    parameter int MASK_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                                   ap_clk,
    input  logic                                                   areset,
    input  logic                                                   pulse_in,
    input  logic [MASK_WIDTH-1:0]                                  kernel_valid_in,
    input  ParallelReadWriteConfigurationParameterField            config_params_in,
    input  ParallelReadWriteConfigurationMeta                      config_meta_in,
    input  logic                                                   start_in,
    input  logic [MASK_WIDTH-1:0]                                  expected_mask_in,
    input  logic                                                   apply_ready_in,
    output logic                                                   apply_valid_out,
    output logic [$clog2(MASK_WIDTH)-1:0]                          apply_slot_out,
    output ParallelReadWriteConfigurationParameterField            apply_params_out,
    output ParallelReadWriteConfigurationParameterField [MASK_WIDTH-1:0] params_bank_out,
    output ParallelReadWriteConfigurationMeta [MASK_WIDTH-1:0]     meta_bank_out,
    output logic [MASK_WIDTH-1:0]                                  slot_updated_out,
    output logic                                                   config_ready_out,
    output logic                                                   overflow_out,
    output logic [CONFIG_PARAMS_UPDATE_DROP_COUNT_WIDTH-1:0]       drop_count_out
);

    localparam int SLOT_W = $clog2(MASK_WIDTH);

    ConfigParamsUpdateState state, state_next;
    ConfigParamsUpdateEntry wr_entry, head;
    logic                   fifo_full, fifo_empty;
    logic                   capture, push_en, push_ok, pop_fire, drop;
    logic [SLOT_W-1:0]      cap_slot;
    logic [MASK_WIDTH-1:0]  expected_mask;

    always_comb begin
        cap_slot = '0;
        for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
            if (kernel_valid_in[i]) cap_slot = SLOT_W'(i);
        end
    end

    assign capture  = pulse_in & (|kernel_valid_in);
    assign push_en  = capture & (start_in | (state != IDLE));
    assign pop_fire = apply_valid_out & apply_ready_in & ~start_in;
    assign push_ok  = push_en & (start_in | ~fifo_full | pop_fire);
    assign drop     = push_en & ~push_ok;
    assign wr_entry = '{slot: cap_slot, params: config_params_in, meta: config_meta_in};

    config_params_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (areset),
        .flush (start_in),
        .push  (push_en),
        .pop   (pop_fire),
        .entry (wr_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign apply_valid_out  = ~fifo_empty;
    assign apply_slot_out   = head.slot;
    assign apply_params_out = head.params;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            ARMED:   if (fifo_empty && !push_ok &&
                         ((slot_updated_out & expected_mask) == expected_mask)) state_next = READY;
            READY:   state_next = READY;
            default: state_next = IDLE;
        endcase
        if (start_in) state_next = ARMED;
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state            <= IDLE;
            config_ready_out <= 1'b0;
            expected_mask    <= '0;
            overflow_out     <= 1'b0;
        end else begin
            state            <= state_next;
            config_ready_out <= (state_next == READY);
            if (start_in) begin
                expected_mask <= expected_mask_in;
                overflow_out  <= 1'b0;
            end else if (drop) begin
                overflow_out  <= 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            params_bank_out  <= '0;
            meta_bank_out    <= '0;
            slot_updated_out <= '0;
        end else begin
            if (start_in) begin
                slot_updated_out <= '0;
            end else if (pop_fire) begin
                slot_updated_out[head.slot] <= 1'b1;
            end
            if (pop_fire) begin
                params_bank_out[head.slot] <= head.params;
                meta_bank_out[head.slot]   <= head.meta;
            end
        end
    end

`ifdef CONFIG_PARAMS_UPDATE_DROP_COUNT_EN
    localparam logic [CONFIG_PARAMS_UPDATE_DROP_COUNT_WIDTH-1:0] DROP_ONE = 1;
    logic idle_discard;

    assign idle_discard = capture & ~start_in & (state == IDLE);

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            drop_count_out <= '0;
        end else if (start_in) begin
            drop_count_out <= '0;
        end else if ((drop || idle_discard) && (drop_count_out != '1)) begin
            drop_count_out <= drop_count_out + DROP_ONE;
        end
    end
`else
    assign drop_count_out = '0;
`endif

endmodule

// File: tb/tb_config_params_update_stage.sv
// Self-checking bench: per-cycle queue scoreboard plus table vectors and corner sequences.
module tb_config_params_update_stage;
    import config_params_update_pkg::*;

    localparam int MW    = 8;
    localparam int DEPTH = 4;
`ifdef CONFIG_PARAMS_UPDATE_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic ap_clk = 1'b0;
    logic areset = 1'b1;
    logic pulse_in = 1'b0;
    logic start_in = 1'b0;
    logic apply_ready_in = 1'b0;
    logic [MW-1:0] kernel_valid_in = '0;
    logic [MW-1:0] expected_mask_in = '0;
    ParallelReadWriteConfigurationParameterField config_params_in = '0;
    ParallelReadWriteConfigurationMeta           config_meta_in = '0;

    logic                                             apply_valid_out;
    logic [2:0]                                       apply_slot_out;
    ParallelReadWriteConfigurationParameterField      apply_params_out;
    ParallelReadWriteConfigurationParameterField [MW-1:0] params_bank_out;
    ParallelReadWriteConfigurationMeta [MW-1:0]       meta_bank_out;
    logic [MW-1:0]                                    slot_updated_out;
    logic                                             config_ready_out;
    logic                                             overflow_out;
    logic [15:0]                                      drop_count_out;

    config_params_update_stage #(.MASK_WIDTH(MW), .FIFO_DEPTH(DEPTH)) dut (
        .ap_clk           (ap_clk),
        .areset           (areset),
        .pulse_in         (pulse_in),
        .kernel_valid_in  (kernel_valid_in),
        .config_params_in (config_params_in),
        .config_meta_in   (config_meta_in),
        .start_in         (start_in),
        .expected_mask_in (expected_mask_in),
        .apply_ready_in   (apply_ready_in),
        .apply_valid_out  (apply_valid_out),
        .apply_slot_out   (apply_slot_out),
        .apply_params_out (apply_params_out),
        .params_bank_out  (params_bank_out),
        .meta_bank_out    (meta_bank_out),
        .slot_updated_out (slot_updated_out),
        .config_ready_out (config_ready_out),
        .overflow_out     (overflow_out),
        .drop_count_out   (drop_count_out)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { logic [2:0] slot; logic [31:0] params; logic [7:0] meta; } exp_entry_t;
    typedef struct { logic [7:0] kv; logic [31:0] params; logic [7:0] meta; logic [2:0] slot; } vec_t;

    exp_entry_t q[$];
    vec_t       vecs[5];
    int         checks = 0;
    int         errors = 0;
    int         m_state, m_drop;
    logic [7:0] m_mask, m_upd;
    logic       m_ovf;
    logic [31:0] m_pbank [MW];
    logic [7:0]  m_mbank [MW];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r = '0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_state = 0; m_drop = 0; m_mask = '0; m_upd = '0; m_ovf = 1'b0;
        for (int i = 0; i < MW; i++) begin m_pbank[i] = '0; m_mbank[i] = '0; end
    endtask

    task automatic check_banks(input string tag);
        logic [255:0] pv = '0;
        logic [63:0]  mv = '0;
        for (int i = 0; i < MW; i++) begin
            pv[i*32 +: 32] = m_pbank[i];
            mv[i*8 +: 8]   = m_mbank[i];
        end
        chk({tag, "_params_bank"}, params_bank_out, pv);
        chk({tag, "_meta_bank"}, meta_bank_out, {192'd0, mv});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_apply_valid"}, apply_valid_out, 1'b0);
        chk({tag, "_apply_slot"}, apply_slot_out, 3'd0);
        chk({tag, "_apply_params"}, apply_params_out, 32'd0);
        chk({tag, "_slot_updated"}, slot_updated_out, 8'd0);
        chk({tag, "_config_ready"}, config_ready_out, 1'b0);
        chk({tag, "_overflow"}, overflow_out, 1'b0);
        chk({tag, "_drop_count"}, drop_count_out, 16'd0);
        chk({tag, "_params_bank"}, params_bank_out, 256'd0);
        chk({tag, "_meta_bank"}, meta_bank_out, 256'd0);
    endtask

    // One clock: update the model from the driven inputs, clock, then compare.
    task automatic step();
        bit cap, pop, push, drop;
        int nstate;
        exp_entry_t e;
        cap = pulse_in && (kernel_valid_in != 0);
        pop = 0; push = 0; drop = 0;
        nstate = m_state;
        if (start_in) begin
            q.delete();
            push = cap;
            nstate = 1;
            m_upd = '0; m_ovf = 1'b0; m_drop = 0; m_mask = expected_mask_in;
        end else begin
            pop = apply_ready_in && (q.size() > 0);
            if (m_state != 0 && cap) begin
                push = (q.size() < DEPTH) || pop;
                drop = !push;
            end
            if (m_state == 0 && cap && m_drop < 65535) m_drop++;
            if (m_state == 1 && q.size() == 0 && !push && ((m_upd & m_mask) == m_mask)) nstate = 2;
        end
        if (pop) begin
            e = q.pop_front();
            m_pbank[e.slot] = e.params;
            m_mbank[e.slot] = e.meta;
            m_upd[e.slot] = 1'b1;
        end
        if (push) q.push_back('{lowest(kernel_valid_in), config_params_in, config_meta_in});
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        m_state = nstate;
        @(posedge ap_clk);
        #1;
        chk("apply_valid", apply_valid_out, q.size() > 0);
        if (q.size() > 0) begin
            chk("head_slot", apply_slot_out, q[0].slot);
            chk("head_params", apply_params_out, q[0].params);
        end
        chk("slot_updated", slot_updated_out, m_upd);
        chk("overflow", overflow_out, m_ovf);
        chk("config_ready", config_ready_out, m_state == 2);
        chk("drop_count", drop_count_out, DROP_EN ? 16'(m_drop) : 16'd0);
    endtask

    task automatic capture(input logic [7:0] kv, input logic [31:0] p, input logic [7:0] m);
        pulse_in = 1'b1; kernel_valid_in = kv; config_params_in = p; config_meta_in = m;
        step();
        pulse_in = 1'b0; kernel_valid_in = '0;
    endtask

    task automatic start_epoch(input logic [7:0] mask);
        start_in = 1'b1; expected_mask_in = mask;
        step();
        start_in = 1'b0;
    endtask

    task automatic run_vec(input int i);
        apply_ready_in = 1'b0;
        capture(vecs[i].kv, vecs[i].params, vecs[i].meta);
        chk("vec_slot", apply_slot_out, vecs[i].slot);
        chk("vec_params", apply_params_out, vecs[i].params);
        apply_ready_in = 1'b1;
        step();
        apply_ready_in = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{8'b1111_1111, 32'hA000_0001, 8'h11, 3'd0};
        vecs[1] = '{8'b1111_1100, 32'hA000_0022, 8'h22, 3'd2};
        vecs[2] = '{8'b1000_0000, 32'hB700_0007, 8'h77, 3'd7};
        vecs[3] = '{8'b0010_1000, 32'hC300_0003, 8'h33, 3'd3};
        vecs[4] = '{8'b1111_0000, 32'hD400_0004, 8'h44, 3'd4};
        model_reset();

        #12;
        check_zero("reset");
        areset = 1'b0;
        step();

        // IDLE: real capture discarded, pulse with empty mask is not a capture
        capture(8'hFF, 32'hDEAD_BEEF, 8'h5A);
        capture(8'h00, 32'h1234_5678, 8'hA5);
        chk("idle_no_valid", apply_valid_out, 1'b0);
        chk("idle_bank", params_bank_out, 256'd0);

        // Epoch expecting slots 0 and 2
        start_epoch(8'b0000_0101);
        run_vec(0);
        run_vec(1);
        chk("ready_one_after_apply", config_ready_out, 1'b0);
        step();
        chk("ready_two_after_apply", config_ready_out, 1'b1);
        chk("slot_updated_05", slot_updated_out, 8'h05);
        chk("bank0", params_bank_out[0], vecs[0].params);
        chk("bank2", params_bank_out[2], vecs[1].params);
        for (int i = 2; i < 5; i++) run_vec(i);
        chk("slot_updated_9d", slot_updated_out, 8'h9D);
        chk("bank7", params_bank_out[7], vecs[2].params);
        chk("meta3", meta_bank_out[3], vecs[3].meta);
        check_banks("table");

        // Fill, simultaneous push+pop at full, then overflow
        start_epoch(8'hFF);
        apply_ready_in = 1'b0;
        for (int i = 0; i < DEPTH; i++) capture(8'($urandom_range(1, 255)), $urandom(), 8'($urandom()));
        apply_ready_in = 1'b1;
        capture(8'($urandom_range(1, 255)), $urandom(), 8'($urandom()));
        chk("full_pushpop_no_ovf", overflow_out, 1'b0);
        apply_ready_in = 1'b0;
        capture(8'($urandom_range(1, 255)), $urandom(), 8'($urandom()));
        chk("overflow_set", overflow_out, 1'b1);
        chk("drop_one", drop_count_out, DROP_EN ? 16'd1 : 16'd0);
        apply_ready_in = 1'b1;
        n = 0;
        while (apply_valid_out && n < 10) begin
            step();
            n++;
        end
        chk("drained_entries", 32'(n), 32'd4);
        check_banks("drain");

        // READY with overflow, then start concurrent with a slot-3 capture
        apply_ready_in = 1'b0;
        start_epoch(8'h00);
        step();
        chk("ready_empty_mask", config_ready_out, 1'b1);
        for (int i = 0; i < 5; i++) capture(8'($urandom_range(1, 255)), $urandom(), 8'($urandom()));
        chk("ready_overflow", overflow_out, 1'b1);
        start_in = 1'b1; expected_mask_in = 8'h08;
        capture(8'b0000_1000, 32'h3333_0003, 8'h03);
        start_in = 1'b0;
        chk("restart_valid", apply_valid_out, 1'b1);
        chk("restart_slot", apply_slot_out, 3'd3);
        chk("restart_updated", slot_updated_out, 8'h00);
        chk("restart_not_ready", config_ready_out, 1'b0);
        chk("restart_ovf_clear", overflow_out, 1'b0);
        step();
        apply_ready_in = 1'b1;
        step();
        chk("restart_single_entry", apply_valid_out, 1'b0);
        step();
        chk("restart_ready", config_ready_out, 1'b1);

        // Asynchronous reset mid-drain
        apply_ready_in = 1'b0;
        start_epoch(8'hFF);
        for (int i = 0; i < 3; i++) capture(8'($urandom_range(1, 255)), $urandom(), 8'($urandom()));
        apply_ready_in = 1'b1;
        step();
        #1 areset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        apply_ready_in = 1'b0;
        #2 areset = 1'b0;
        step();
        chk("post_reset_empty", apply_valid_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
